csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_pkg.sv | 21 ++
 rtl/csr_regfile_if.sv | 27 ++
 rtl/csr_counter.sv | 17 +
 rtl/csr_regfile.sv | 92 +++++++++
 tb/tb_csr_regfile.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, mstatus bit positions and redirect FSM encoding.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_e;
  function automatic logic [63:0] mstatus_view(input logic ie, input logic pie);
    mstatus_view = 64'h1800;
    mstatus_view[MSTATUS_MIE] = ie;
    mstatus_view[MSTATUS_MPIE] = pie;
  endfunction
endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: read/write, trap/mret and redirect signals of the CSR file.
interface csr_regfile_if;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        trap_valid;
  logic [63:0] trap_pc;
  logic [63:0] trap_cause;
  logic [63:0] trap_tval;
  logic        mret_valid;
  logic        instr_retire;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata, trap_valid, trap_pc, trap_cause,
           trap_tval, mret_valid, instr_retire,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, trap_valid, trap_pc, trap_cause,
           trap_tval, mret_valid, instr_retire,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: 64-bit wrapping counter where a write load takes priority over increment.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q, cnt_d;
  assign cnt_d = we_i ? wdata_i : inc_i ? cnt_q + 64'd1 : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSRs with trap/mret fetch redirect.
// Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_regfile
  import csr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  csr_regfile_if.slave  bus
);
  logic        ie_q, ie_d, pie_q, pie_d;
  logic [63:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] rpc_q, rpc_d;
  state_e      state_q, state_d;
  logic        trap, mret;
  logic [63:0] wd;
  assign trap = bus.trap_valid;
  assign mret = bus.mret_valid & ~bus.trap_valid;
  assign wd   = bus.csr_wdata;
  function automatic logic hit(input logic [11:0] a);
    hit = bus.csr_we && bus.csr_waddr == a;
  endfunction
  // Trap beats mret beats software write for the shared mstatus/mepc/mcause/mtval state.
  always_comb begin
    ie_d       = trap ? 1'b0 : mret ? pie_q : hit(CSR_MSTATUS) ? wd[MSTATUS_MIE] : ie_q;
    pie_d      = trap ? ie_q : mret ? 1'b1 : hit(CSR_MSTATUS) ? wd[MSTATUS_MPIE] : pie_q;
    mie_d      = hit(CSR_MIE) ? wd : mie_q;
    mtvec_d    = hit(CSR_MTVEC) ? {wd[63:2], 2'b00} : mtvec_q;
    mscratch_d = hit(CSR_MSCRATCH) ? wd : mscratch_q;
    mepc_d     = trap ? {bus.trap_pc[63:1], 1'b0} : hit(CSR_MEPC) ? {wd[63:1], 1'b0} : mepc_q;
    mcause_d   = trap ? bus.trap_cause : hit(CSR_MCAUSE) ? wd : mcause_q;
    mtval_d    = trap ? bus.trap_tval : hit(CSR_MTVAL) ? wd : mtval_q;
    state_d    = (trap || mret) ? ST_REDIRECT : ST_RUN;
    rpc_d      = trap ? mtvec_q : mret ? mepc_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q       <= 1'b0;
      pie_q      <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      rpc_q      <= '0;
      state_q    <= ST_RUN;
    end else begin
      ie_q       <= ie_d;
      pie_q      <= pie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      rpc_q      <= rpc_d;
      state_q    <= state_d;
    end
  end
  assign bus.redirect_valid = state_q == ST_REDIRECT;
  assign bus.redirect_pc    = rpc_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  csr_counter u_mcycle (
    .clk(clk), .rst(rst), .inc_i(1'b1), .we_i(hit(CSR_MCYCLE)), .wdata_i(wd), .cnt_o(mcycle)
  );
  csr_counter u_minstret (
    .clk(clk), .rst(rst), .inc_i(bus.instr_retire), .we_i(hit(CSR_MINSTRET)), .wdata_i(wd),
    .cnt_o(minstret)
  );
`endif
  always_comb begin
    bus.csr_rdata   = '0;
    bus.csr_illegal = 1'b0;
    case (bus.csr_raddr)
      CSR_MSTATUS:  bus.csr_rdata = mstatus_view(ie_q, pie_q);
      CSR_MIE:      bus.csr_rdata = mie_q;
      CSR_MTVEC:    bus.csr_rdata = mtvec_q;
      CSR_MSCRATCH: bus.csr_rdata = mscratch_q;
      CSR_MEPC:     bus.csr_rdata = mepc_q;
      CSR_MCAUSE:   bus.csr_rdata = mcause_q;
      CSR_MTVAL:    bus.csr_rdata = mtval_q;
      CSR_MIP:      bus.csr_rdata = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   bus.csr_rdata = mcycle;
      CSR_MINSTRET: bus.csr_rdata = minstret;
`endif
      default:      bus.csr_illegal = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed scoreboard bench for csr_regfile (honours CSR_COUNTERS_EN).
module tb_csr_regfile;
  import csr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  csr_regfile_if bus ();
  csr_regfile dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  typedef struct {string tag; logic [63:0] exp;} exp_t;
  exp_t sb[$];
  task automatic push(input string t, input logic [63:0] e);
    sb.push_back('{t, e});
  endtask
  task automatic check(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic rd(input string t, input logic [11:0] a, input logic [63:0] e, input logic ill);
    bus.csr_raddr = a;
    push({t, "_data"}, e);
    push({t, "_illegal"}, {63'b0, ill});
    #1;
    check(bus.csr_rdata);
    check({63'b0, bus.csr_illegal});
  endtask
  task automatic redir(input string t, input logic v, input logic [63:0] pc);
    push({t, "_rvalid"}, {63'b0, v});
    push({t, "_rpc"}, pc);
    check({63'b0, bus.redirect_valid});
    check(bus.redirect_pc);
  endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.csr_we = 1'b1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
  endtask
  task automatic trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
    bus.trap_valid = 1'b1;
    bus.trap_pc = pc;
    bus.trap_cause = cause;
    bus.trap_tval = tval;
  endtask
  task automatic cyc();
    @(negedge clk);
    bus.csr_we = 1'b0;
    bus.trap_valid = 1'b0;
    bus.mret_valid = 1'b0;
    bus.instr_retire = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end
  initial begin
    bus.csr_raddr = '0;
    bus.csr_we = 1'b0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    bus.trap_valid = 1'b0;
    bus.trap_pc = '0;
    bus.trap_cause = '0;
    bus.trap_tval = '0;
    bus.mret_valid = 1'b0;
    bus.instr_retire = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    rd("rst_mstatus", CSR_MSTATUS, 64'h1800, 1'b0);
    rd("rst_mscratch", CSR_MSCRATCH, 64'h0, 1'b0);
    redir("rst", 1'b0, 64'h0);
    wr(CSR_MSCRATCH, 64'hDEAD_BEEF);
    rd("scratch_old", CSR_MSCRATCH, 64'h0, 1'b0);
    cyc();
    rd("scratch_new", CSR_MSCRATCH, 64'hDEAD_BEEF, 1'b0);
    wr(CSR_MSTATUS, '1);
    cyc();
    rd("mstatus_ones", CSR_MSTATUS, 64'h1888, 1'b0);
    wr(CSR_MSTATUS, 64'h8);
    cyc();
    rd("mstatus_mie", CSR_MSTATUS, 64'h1808, 1'b0);
    wr(CSR_MTVEC, 64'h8000_0103);
    cyc();
    rd("mtvec", CSR_MTVEC, 64'h8000_0100, 1'b0);
    wr(CSR_MEPC, 64'h7);
    cyc();
    rd("mepc_lsb", CSR_MEPC, 64'h6, 1'b0);
    wr(CSR_MIP, '1);
    cyc();
    rd("mip", CSR_MIP, 64'h0, 1'b0);
    trap(64'h1000, 64'd2, 64'h55);
    cyc();
    redir("trap", 1'b1, 64'h8000_0100);
    rd("trap_mepc", CSR_MEPC, 64'h1000, 1'b0);
    rd("trap_mcause", CSR_MCAUSE, 64'd2, 1'b0);
    rd("trap_mtval", CSR_MTVAL, 64'h55, 1'b0);
    rd("trap_mstatus", CSR_MSTATUS, 64'h1880, 1'b0);
    cyc();
    redir("trap_end", 1'b0, 64'h0);
    bus.mret_valid = 1'b1;
    cyc();
    redir("mret", 1'b1, 64'h1000);
    rd("mret_mstatus", CSR_MSTATUS, 64'h1888, 1'b0);
    cyc();
    trap(64'h2000, 64'd3, 64'h0);
    bus.mret_valid = 1'b1;
    cyc();
    redir("trap_mret", 1'b1, 64'h8000_0100);
    rd("trap_mret_mepc", CSR_MEPC, 64'h2000, 1'b0);
    rd("trap_mret_mstatus", CSR_MSTATUS, 64'h1880, 1'b0);
    rd("illegal", 12'h7C0, 64'h0, 1'b1);
    cyc();
    bus.mret_valid = 1'b1;
    wr(CSR_MEPC, 64'h3000);
    cyc();
    redir("mret_wepc", 1'b1, 64'h2000);
    rd("mret_wepc_mepc", CSR_MEPC, 64'h3000, 1'b0);
    rd("mret_wepc_mstatus", CSR_MSTATUS, 64'h1888, 1'b0);
    cyc();
    trap(64'h4000, 64'd5, 64'h0);
    wr(CSR_MSCRATCH, 64'h1234);
    cyc();
    redir("trap_we", 1'b1, 64'h8000_0100);
    rd("trap_we_scratch", CSR_MSCRATCH, 64'h1234, 1'b0);
    rd("trap_we_mcause", CSR_MCAUSE, 64'd5, 1'b0);
    bus.mret_valid = 1'b1;
    cyc();
    redir("mret_in_redirect", 1'b1, 64'h4000);
    rd("mret_in_redirect_mstatus", CSR_MSTATUS, 64'h1888, 1'b0);
    cyc();
    redir("idle", 1'b0, 64'h0);
    trap(64'h5000, 64'd7, 64'h0);
    cyc();
    redir("pre_rst", 1'b1, 64'h8000_0100);
    rst = 1'b1;
    cyc();
    redir("rst_abort", 1'b0, 64'h0);
    rd("rst_mtvec", CSR_MTVEC, 64'h0, 1'b0);
    rd("rst_mstatus2", CSR_MSTATUS, 64'h1800, 1'b0);
    rst = 1'b0;
`ifdef CSR_COUNTERS_EN
    wr(CSR_MCYCLE, '1);
    cyc();
    rd("mcycle_max", CSR_MCYCLE, '1, 1'b0);
    cyc();
    rd("mcycle_wrap", CSR_MCYCLE, 64'h0, 1'b0);
    repeat (3) begin
      bus.instr_retire = 1'b1;
      cyc();
    end
    rd("minstret", CSR_MINSTRET, 64'd3, 1'b0);
    bus.instr_retire = 1'b1;
    wr(CSR_MINSTRET, 64'h10);
    cyc();
    rd("minstret_we_wins", CSR_MINSTRET, 64'h10, 1'b0);
`else
    rd("no_mcycle", CSR_MCYCLE, 64'h0, 1'b1);
    rd("no_minstret", CSR_MINSTRET, 64'h0, 1'b1);
`endif
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
